// File: rtl/dma_xfer_down_counter.sv
// DMA transfer-length tracker: loads start address and word count, counts acknowledged beats down.
// Optional DMA_XFER_AUTORELOAD_EN: shadow registers restart the same transfer after each completion.
module dma_xfer_down_counter #(
    parameter int unsigned L    = 16,
    parameter int unsigned A    = 16,
    parameter int unsigned STEP = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [A-1:0] addr_in,
    input  logic [L-1:0] len_in,
    input  logic         xfer_ack,
    output logic         busy,
    output logic         done,
    output logic         last,
    output logic [L-1:0] remaining,
    output logic [A-1:0] addr_out
);

    localparam logic [L-1:0] ONE_L  = L'(1);
    localparam logic [A-1:0] STEP_A = A'(STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t       state, state_nxt;
    logic [L-1:0] rem_q, rem_nxt;
    logic [A-1:0] addr_q, addr_nxt;

`ifdef DMA_XFER_AUTORELOAD_EN
    logic [L-1:0] shadow_len_q, shadow_len_nxt;
    logic [A-1:0] shadow_addr_q, shadow_addr_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rem_q  <= '0;
            addr_q <= '0;
`ifdef DMA_XFER_AUTORELOAD_EN
            shadow_len_q  <= '0;
            shadow_addr_q <= '0;
`endif
        end else begin
            state  <= state_nxt;
            rem_q  <= rem_nxt;
            addr_q <= addr_nxt;
`ifdef DMA_XFER_AUTORELOAD_EN
            shadow_len_q  <= shadow_len_nxt;
            shadow_addr_q <= shadow_addr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem_q;
        addr_nxt  = addr_q;
`ifdef DMA_XFER_AUTORELOAD_EN
        shadow_len_nxt  = shadow_len_q;
        shadow_addr_nxt = shadow_addr_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nxt = addr_in;
`ifdef DMA_XFER_AUTORELOAD_EN
                    shadow_len_nxt  = len_in;
                    shadow_addr_nxt = addr_in;
`endif
                    if (len_in != '0) begin
                        rem_nxt   = len_in;
                        state_nxt = S_BUSY;
                    end else begin
                        rem_nxt   = '0;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                // abort has priority: the concurrent ack is dropped
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (xfer_ack) begin
                    rem_nxt  = rem_q - ONE_L;
                    addr_nxt = addr_q + STEP_A;
                    if (rem_q == ONE_L) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
`ifdef DMA_XFER_AUTORELOAD_EN
                // a zero-length load never loops
                if (abort || shadow_len_q == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    rem_nxt   = shadow_len_q;
                    addr_nxt  = shadow_addr_q;
                    state_nxt = S_BUSY;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state == S_BUSY);
    assign done      = (state == S_DONE);
    assign last      = busy && (rem_q == ONE_L);
    assign remaining = rem_q;
    assign addr_out  = addr_q;

endmodule

// File: tb/tb_dma_xfer_down_counter.sv
// Directed self-checking bench for dma_xfer_down_counter (default build; autoreload section
// compiled only when DMA_XFER_AUTORELOAD_EN is defined).
module tb_dma_xfer_down_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] addr_in;
    logic [15:0] len_in;
    logic        xfer_ack;
    logic        busy;
    logic        done;
    logic        last;
    logic [15:0] remaining;
    logic [15:0] addr_out;

    int checks = 0;
    int errors = 0;

    dma_xfer_down_counter #(.L(16), .A(16), .STEP(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .addr_in   (addr_in),
        .len_in    (len_in),
        .xfer_ack  (xfer_ack),
        .busy      (busy),
        .done      (done),
        .last      (last),
        .remaining (remaining),
        .addr_out  (addr_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are then sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic b, input logic d, input logic l,
                             input logic [15:0] rem, input logic [15:0] adr);
        check_eq({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        check_eq({tag, ".done"}, {31'd0, done}, {31'd0, d});
        check_eq({tag, ".last"}, {31'd0, last}, {31'd0, l});
        check_eq({tag, ".rem"},  {16'd0, remaining}, {16'd0, rem});
        check_eq({tag, ".addr"}, {16'd0, addr_out},  {16'd0, adr});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; addr_in = '0; len_in = '0; xfer_ack = 1'b0;

        // 1. reset
        tick(); tick();
        rst = 1'b0;
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // 2. basic count, ack every cycle
        start = 1'b1; addr_in = 16'h1000; len_in = 16'd3; xfer_ack = 1'b1;
        tick();
        start = 1'b0;
        check_all("basic.b1", 1'b1, 1'b0, 1'b0, 16'd3, 16'h1000);
        tick();
        check_all("basic.b2", 1'b1, 1'b0, 1'b0, 16'd2, 16'h1002);
        tick();
        check_all("basic.b3", 1'b1, 1'b0, 1'b1, 16'd1, 16'h1004);
        tick();
        check_all("basic.done", 1'b0, 1'b1, 1'b0, 16'd0, 16'h1006);
        tick();
        check_all("basic.idle", 1'b0, 1'b0, 1'b0, 16'd0, 16'h1006);
        xfer_ack = 1'b0;

        // 3. gapped acks then abort together with an ack
        start = 1'b1; addr_in = 16'h2000; len_in = 16'd5;
        tick();
        start = 1'b0;
        check_all("gap.load", 1'b1, 1'b0, 1'b0, 16'd5, 16'h2000);
        xfer_ack = 1'b1; tick();
        check_all("gap.ack1", 1'b1, 1'b0, 1'b0, 16'd4, 16'h2002);
        xfer_ack = 1'b0; tick();
        check_all("gap.hole", 1'b1, 1'b0, 1'b0, 16'd4, 16'h2002);
        xfer_ack = 1'b1; tick();
        check_all("gap.ack2", 1'b1, 1'b0, 1'b0, 16'd3, 16'h2004);
        abort = 1'b1; xfer_ack = 1'b1; tick();
        abort = 1'b0; xfer_ack = 1'b0;
        check_all("abort", 1'b0, 1'b0, 1'b0, 16'd3, 16'h2004);
        tick();
        check_all("abort.idle", 1'b0, 1'b0, 1'b0, 16'd3, 16'h2004);

        // 4a. zero length: straight to a single done pulse
        start = 1'b1; addr_in = 16'h3000; len_in = 16'd0;
        tick();
        start = 1'b0;
        check_all("len0.done", 1'b0, 1'b1, 1'b0, 16'd0, 16'h3000);
        tick();
        check_all("len0.idle", 1'b0, 1'b0, 1'b0, 16'd0, 16'h3000);

        // 4b. address wrap through zero
        start = 1'b1; addr_in = 16'hFFFE; len_in = 16'd2; xfer_ack = 1'b1;
        tick();
        start = 1'b0;
        check_all("wrap.b1", 1'b1, 1'b0, 1'b0, 16'd2, 16'hFFFE);
        tick();
        check_all("wrap.b2", 1'b1, 1'b0, 1'b1, 16'd1, 16'h0000);
        tick();
        check_all("wrap.done", 1'b0, 1'b1, 1'b0, 16'd0, 16'h0002);
        xfer_ack = 1'b0;
        tick();

        // 4c. maximum length loads without truncation
        start = 1'b1; addr_in = 16'h0100; len_in = 16'hFFFF;
        tick();
        start = 1'b0;
        check_all("maxlen", 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0100);
        abort = 1'b1; tick(); abort = 1'b0;
        check_all("maxlen.abort", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0100);

        // 5a. start during BUSY ignored
        start = 1'b1; addr_in = 16'h4000; len_in = 16'd2;
        tick();
        check_all("restart.load", 1'b1, 1'b0, 1'b0, 16'd2, 16'h4000);
        start = 1'b1; addr_in = 16'h5000; len_in = 16'd7; xfer_ack = 1'b1;
        tick();
        start = 1'b0;
        check_all("restart.ign", 1'b1, 1'b0, 1'b1, 16'd1, 16'h4002);
        tick();
        check_all("restart.done", 1'b0, 1'b1, 1'b0, 16'd0, 16'h4004);
        xfer_ack = 1'b0;
        tick();

        // 5b. reset mid-BUSY
        start = 1'b1; addr_in = 16'h6000; len_in = 16'd4;
        tick();
        start = 1'b0; xfer_ack = 1'b1;
        tick();
        check_all("rstmid.pre", 1'b1, 1'b0, 1'b0, 16'd3, 16'h6002);
        rst = 1'b1;
        tick();
        check_all("rstmid", 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
        rst = 1'b0;
        tick();
        check_all("rstmid.after", 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
        xfer_ack = 1'b0;

`ifdef DMA_XFER_AUTORELOAD_EN
        // 6. autoreload loop, then abort during DONE
        start = 1'b1; addr_in = 16'h7000; len_in = 16'd2; xfer_ack = 1'b1;
        tick();
        start = 1'b0;
        check_all("ar.b1", 1'b1, 1'b0, 1'b0, 16'd2, 16'h7000);
        tick();
        check_all("ar.b2", 1'b1, 1'b0, 1'b1, 16'd1, 16'h7002);
        tick();
        check_all("ar.done1", 1'b0, 1'b1, 1'b0, 16'd0, 16'h7004);
        tick();
        check_all("ar.reload", 1'b1, 1'b0, 1'b0, 16'd2, 16'h7000);
        tick();
        check_all("ar.b2b", 1'b1, 1'b0, 1'b1, 16'd1, 16'h7002);
        tick();
        check_all("ar.done2", 1'b0, 1'b1, 1'b0, 16'd0, 16'h7004);
        abort = 1'b1;
        tick();
        abort = 1'b0; xfer_ack = 1'b0;
        check_all("ar.abort", 1'b0, 1'b0, 1'b0, 16'd0, 16'h7004);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
